// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V main control unit: states, opcodes,
// ALUOp and ALU source selects, plus the Moore control-word decode of each state.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_WB_R,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_BRANCH,
        ST_TRAP
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_source;
        logic       pc_write_cond;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // The mem_ready-gated FETCH strobes (ir_write, pc_write) are not part of this word.
    function automatic ctrl_t ctrl_decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
            end
            ST_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            ST_EXEC_R: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALUOP_FUNCT;
            end
            ST_WB_R: begin
                c.reg_write = 1'b1;
            end
            ST_MEM_ADDR: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = SRCA_REG;
                c.alu_src_b     = SRCB_REG;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/main_control_fsm_if.sv
// Bundle between the main control unit (master) and the datapath it steers (slave).
interface main_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             pc_source;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             illegal_instr;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               illegal_instr, instret
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               illegal_instr, instret
    );
endinterface

// File: rtl/main_control_fsm.sv
// Multi-cycle RISC-V main control: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencing
// for R-type, ld, sd and beq, with a sticky trap on anything else.
module main_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    main_control_fsm_if.master bus
);

    state_t           state_reg;
    state_t           state_next;
    ctrl_t            ctrl_reg;
    logic             illegal_reg;
    logic [CNT_W-1:0] instret_reg;
    logic             retire;
    logic             fetch_ack;
    logic             unused_zero;

    // The branch decision (zero AND pc_write_cond) is made in the datapath.
    assign unused_zero = bus.zero;

    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                if (bus.mem_ready) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:          state_next = ST_EXEC_R;
                    OP_LOAD, OP_STORE: state_next = ST_MEM_ADDR;
                    OP_BRANCH:         state_next = ST_BRANCH;
                    default:           state_next = ST_TRAP;
                endcase
            end
            ST_EXEC_R: state_next = ST_WB_R;
            ST_WB_R: begin
                state_next = ST_FETCH;
                retire     = 1'b1;
            end
            ST_MEM_ADDR: begin
                if (bus.opcode == OP_LOAD)       state_next = ST_MEM_RD;
                else if (bus.opcode == OP_STORE) state_next = ST_MEM_WR;
                else                             state_next = ST_TRAP;
            end
            ST_MEM_RD: begin
                if (bus.mem_ready) state_next = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                state_next = ST_FETCH;
                retire     = 1'b1;
            end
            ST_MEM_WR: begin
                if (bus.mem_ready) begin
                    state_next = ST_FETCH;
                    retire     = 1'b1;
                end
            end
            ST_BRANCH: begin
                state_next = ST_FETCH;
                retire     = 1'b1;
            end
            ST_TRAP: state_next = ST_TRAP;
            default: state_next = ST_FETCH;
        endcase
    end

    // Control word is registered from the next state, so it always matches state_reg.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_FETCH;
            ctrl_reg    <= ctrl_decode(ST_FETCH);
            illegal_reg <= 1'b0;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= ctrl_decode(state_next);
            if (state_reg == ST_TRAP) illegal_reg <= 1'b1;
            if (retire) instret_reg <= instret_reg + CNT_W'(1);
        end
    end

    assign fetch_ack = (state_reg == ST_FETCH) && bus.mem_ready;

    assign bus.ir_write      = fetch_ack & ~reset;
    assign bus.pc_write      = fetch_ack & ~reset;
    assign bus.pc_write_cond = ctrl_reg.pc_write_cond & ~reset;
    assign bus.pc_source     = ctrl_reg.pc_source & ~reset;
    assign bus.i_or_d        = ctrl_reg.i_or_d & ~reset;
    assign bus.mem_read      = ctrl_reg.mem_read & ~reset;
    assign bus.mem_write     = ctrl_reg.mem_write & ~reset;
    assign bus.reg_write     = ctrl_reg.reg_write & ~reset;
    assign bus.mem_to_reg    = ctrl_reg.mem_to_reg & ~reset;
    assign bus.alu_src_a     = reset ? 2'b00 : ctrl_reg.alu_src_a;
    assign bus.alu_src_b     = reset ? 2'b00 : ctrl_reg.alu_src_b;
    assign bus.alu_op        = reset ? 2'b00 : ctrl_reg.alu_op;
    assign bus.illegal_instr = illegal_reg;
    assign bus.instret       = instret_reg;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: walks each instruction class cycle by cycle and
// compares the full control word against hand-written per-state vectors.
module tb_main_control_fsm;

    localparam int TB_CNT_W = 3;

    // {pc_write, pc_write_cond, pc_source, i_or_d}_{mem_read, mem_write, ir_write, reg_write}
    // _{mem_to_reg}_{alu_src_a}_{alu_src_b}_{alu_op}
    localparam logic [14:0] V_F_RDY  = 15'b1000_1010_0_00_01_00;
    localparam logic [14:0] V_F_WAIT = 15'b0000_1000_0_00_01_00;
    localparam logic [14:0] V_DEC    = 15'b0000_0000_0_01_10_00;
    localparam logic [14:0] V_EXR    = 15'b0000_0000_0_10_00_10;
    localparam logic [14:0] V_WBR    = 15'b0000_0001_0_00_00_00;
    localparam logic [14:0] V_MADR   = 15'b0000_0000_0_10_10_00;
    localparam logic [14:0] V_MRD    = 15'b0001_1000_0_00_00_00;
    localparam logic [14:0] V_MWB    = 15'b0000_0001_1_00_00_00;
    localparam logic [14:0] V_MWR    = 15'b0001_0100_0_00_00_00;
    localparam logic [14:0] V_BR     = 15'b0110_0000_0_10_00_01;
    localparam logic [14:0] V_ZERO   = 15'b0000_0000_0_00_00_00;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_SD  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_BAD = 7'b1111111;

    logic        clock;
    logic        reset;
    logic [14:0] obs;
    int          n_cmp;
    int          n_bad;

    main_control_fsm_if #(.CNT_W(TB_CNT_W)) bus ();

    main_control_fsm #(.CNT_W(TB_CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign obs = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d,
                  bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write,
                  bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge: apply mem_ready, check mid-cycle, advance one clock.
    task automatic cyc(input string tag, input logic [14:0] exp, input logic ready);
        bus.mem_ready = ready;
        @(negedge clock);
        check(tag, 32'(obs), 32'(exp));
        @(posedge clock);
        #1;
    endtask

    task automatic check_instret(input string tag, input int exp);
        check(tag, 32'(bus.instret), 32'(exp));
        $display("%s: instret=%0d illegal=%0b", tag, bus.instret, bus.illegal_instr);
    endtask

    task automatic run_beq(input string tag, input logic z);
        bus.opcode = OPC_BEQ;
        bus.zero   = z;
        cyc({tag, "_fetch"}, V_F_RDY, 1'b1);
        cyc({tag, "_dec"}, V_DEC, 1'b1);
        cyc({tag, "_br"}, V_BR, 1'b0);
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        reset         = 1'b1;
        bus.opcode    = 7'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Controls forced low while reset is held, even with mem_ready high.
        cyc("rst_forced", V_ZERO, 1'b1);
        reset = 1'b0;
        check("rst_instret", 32'(bus.instret), 32'd0);
        check("rst_illegal", 32'(bus.illegal_instr), 32'd0);

        // R-type: 4 cycles, mem_ready ignored outside FETCH
        bus.opcode = OPC_R;
        cyc("r_fetch", V_F_RDY, 1'b1);
        cyc("r_dec", V_DEC, 1'b1);
        cyc("r_exec", V_EXR, 1'b1);
        cyc("r_wb", V_WBR, 1'b1);
        check_instret("r_done", 1);

        // ld with three wait cycles in MEM_RD: 8 cycles total
        bus.opcode = OPC_LD;
        cyc("ld_fetch", V_F_RDY, 1'b1);
        cyc("ld_dec", V_DEC, 1'b0);
        cyc("ld_addr", V_MADR, 1'b0);
        for (int i = 0; i < 3; i++) cyc("ld_rd_wait", V_MRD, 1'b0);
        cyc("ld_rd_ack", V_MRD, 1'b1);
        cyc("ld_wb", V_MWB, 1'b0);
        check_instret("ld_done", 2);

        // sd with one wait cycle
        bus.opcode = OPC_SD;
        cyc("sd_fetch", V_F_RDY, 1'b1);
        cyc("sd_dec", V_DEC, 1'b1);
        cyc("sd_addr", V_MADR, 1'b1);
        cyc("sd_wr_wait", V_MWR, 1'b0);
        cyc("sd_wr_ack", V_MWR, 1'b1);
        check_instret("sd_done", 3);

        // beq taken and not taken; second one preceded by two fetch wait cycles
        run_beq("beq_z1", 1'b1);
        check_instret("beq_z1_done", 4);
        bus.opcode = OPC_BEQ;
        cyc("fetch_wait0", V_F_WAIT, 1'b0);
        cyc("fetch_wait1", V_F_WAIT, 1'b0);
        run_beq("beq_z0", 1'b0);
        check_instret("beq_z0_done", 5);

        // instret wraps modulo 2^3
        run_beq("wrap_a", 1'b0);
        run_beq("wrap_b", 1'b1);
        check_instret("wrap_7", 7);
        run_beq("wrap_c", 1'b0);
        check_instret("wrap_0", 0);

        // Reset while MEM_WR is waiting abandons the store
        bus.opcode = OPC_SD;
        cyc("sdr_fetch", V_F_RDY, 1'b1);
        cyc("sdr_dec", V_DEC, 1'b0);
        cyc("sdr_addr", V_MADR, 1'b0);
        cyc("sdr_wr_wait", V_MWR, 1'b0);
        reset = 1'b1;
        cyc("sdr_in_reset", V_ZERO, 1'b0);
        reset = 1'b0;
        cyc("sdr_after_wait", V_F_WAIT, 1'b0);
        check_instret("sdr_done", 0);

        // Illegal opcode traps and stays trapped for 20 cycles
        bus.opcode = OPC_BAD;
        cyc("bad_fetch", V_F_RDY, 1'b1);
        cyc("bad_dec", V_DEC, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc("trap_ctrl", V_ZERO, 1'(i % 2));
            if (i >= 1) check("trap_illegal", 32'(bus.illegal_instr), 32'd1);
        end
        check_instret("trap_done", 0);
        reset = 1'b1;
        cyc("trap_reset", V_ZERO, 1'b1);
        reset = 1'b0;
        check("trap_clr_illegal", 32'(bus.illegal_instr), 32'd0);
        cyc("trap_clr_fetch", V_F_WAIT, 1'b0);
        cyc("trap_clr_fetch_rdy", V_F_RDY, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
